block_pixel_compositor: RTL and testbench

- Downstream stage of the per-block sprite renderers.
- Merges the 8-bit colour streams of NUM_BLOCKS block renderers into the single 8-bit RGB pixel sent to the VGA DAC.
- Adds playfield background and border, and re-aligns sync/blank to the renderers' pipeline latency.
- Reports per-frame block overlap (collision) statistics to game logic.

---
 rtl/block_pixel_compositor.sv | 202 ++++++++++++++++++++
 tb/tb_block_pixel_compositor.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/block_pixel_compositor.sv
// Pixel compositor: merges NUM_BLOCKS block-renderer colour streams with the
// playfield background/border, re-aligns sync/blank to the renderer latency
// and reports per-frame block overlap statistics.
//
// Ports:
//   vclk, rst                 pixel clock, async active-high reset
//   hcount, vcount            timing-generator coordinates
//   hsync_in, vsync_in        syncs aligned with hcount
//   blank_in                  blanking aligned with hcount
//   pixel_bus, block_en       block colours/enables, PIPE_DELAY cycles after hcount
//   rgb, hsync, vsync, blank  registered composited pixel and delayed timing
//   frame_start               one-cycle pulse at the first pixel of a frame
//   collision, overlap_count  previous-frame overlap report (count saturates)
module block_pixel_compositor #(
    parameter int unsigned NUM_BLOCKS   = 4,
    parameter int unsigned PIPE_DELAY   = 2,
    parameter logic [7:0]  TRANSPARENT  = 8'h00,
    parameter logic [10:0] FIELD_X0     = 11'd200,
    parameter logic [10:0] FIELD_X1     = 11'd600,
    parameter logic [9:0]  FIELD_Y0     = 10'd40,
    parameter logic [9:0]  FIELD_Y1     = 10'd440,
    parameter int unsigned BORDER_W     = 4,
    parameter logic [7:0]  BG_COLOR     = 8'h24,
    parameter logic [7:0]  BORDER_COLOR = 8'hFF,
    parameter logic        SYNC_IDLE    = 1'b1
) (
    input  logic                      vclk,
    input  logic                      rst,
    input  logic [10:0]               hcount,
    input  logic [9:0]                vcount,
    input  logic                      hsync_in,
    input  logic                      vsync_in,
    input  logic                      blank_in,
    input  logic [8*NUM_BLOCKS-1:0]   pixel_bus,
    input  logic [NUM_BLOCKS-1:0]     block_en,
    output logic [7:0]                rgb,
    output logic                      hsync,
    output logic                      vsync,
    output logic                      blank,
    output logic                      frame_start,
    output logic                      collision,
    output logic [15:0]               overlap_count
);

    localparam int unsigned HW = 12;
    localparam int unsigned VW = 11;

    // Field and border edges in widened arithmetic; border inner edge clamps at 0.
    localparam logic [HW-1:0] FX0  = HW'(FIELD_X0);
    localparam logic [HW-1:0] FX1  = HW'(FIELD_X1);
    localparam logic [HW-1:0] BWX  = HW'(BORDER_W);
    localparam logic [HW-1:0] BX0  = (FX0 > BWX) ? (FX0 - BWX) : HW'(0);
    localparam logic [HW-1:0] BX1  = FX1 + BWX;
    localparam logic [VW-1:0] FY0  = VW'(FIELD_Y0);
    localparam logic [VW-1:0] FY1  = VW'(FIELD_Y1);
    localparam logic [VW-1:0] BWY  = VW'(BORDER_W);
    localparam logic [VW-1:0] BY0  = (FY0 > BWY) ? (FY0 - BWY) : VW'(0);
    localparam logic [VW-1:0] BY1  = FY1 + BWY;

    logic [10:0] dh_q  [PIPE_DELAY];
    logic [9:0]  dv_q  [PIPE_DELAY];
    logic        dhs_q [PIPE_DELAY];
    logic        dvs_q [PIPE_DELAY];
    logic        dbl_q [PIPE_DELAY];

    logic [7:0]  rgb_q, rgb_d;
    logic        hsync_q, vsync_q, blank_q;
    logic        fs_q, fs_d;
    logic        col_q, col_d;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] acc_q, acc_d;

    logic [10:0] dh;
    logic [9:0]  dv;
    logic        dbl;

    assign dh  = dh_q[PIPE_DELAY-1];
    assign dv  = dv_q[PIPE_DELAY-1];
    assign dbl = dbl_q[PIPE_DELAY-1];

    // Timing delay lines aligning coordinates and syncs with pixel_bus.
    always_ff @(posedge vclk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < PIPE_DELAY; i++) begin
                dh_q[i]  <= '0;
                dv_q[i]  <= '0;
                dhs_q[i] <= SYNC_IDLE;
                dvs_q[i] <= SYNC_IDLE;
                dbl_q[i] <= 1'b1;
            end
        end else begin
            dh_q[0]  <= hcount;
            dv_q[0]  <= vcount;
            dhs_q[0] <= hsync_in;
            dvs_q[0] <= vsync_in;
            dbl_q[0] <= blank_in;
            for (int i = 1; i < PIPE_DELAY; i++) begin
                dh_q[i]  <= dh_q[i-1];
                dv_q[i]  <= dv_q[i-1];
                dhs_q[i] <= dhs_q[i-1];
                dvs_q[i] <= dvs_q[i-1];
                dbl_q[i] <= dbl_q[i-1];
            end
        end
    end

    // Compositing priority, overlap detection and frame statistics.
    always_comb begin
        logic [NUM_BLOCKS-1:0] opaque;
        logic [7:0]            pick;
        logic                  seen;
        logic                  multi;
        logic                  in_field;
        logic                  in_border;
        logic                  overlap;
        logic                  boundary;

        opaque = '0;
        pick   = 8'h00;
        seen   = 1'b0;
        multi  = 1'b0;
        rgb_d  = 8'h00;
        fs_d   = 1'b0;
        col_d  = col_q;
        cnt_d  = cnt_q;
        acc_d  = acc_q;

        for (int i = 0; i < NUM_BLOCKS; i++) begin
            opaque[i] = block_en[i] && (pixel_bus[8*i +: 8] != TRANSPARENT);
            if (opaque[i]) begin
                multi = multi | seen;
                seen  = 1'b1;
            end
        end
        // Walk downwards so the lowest-index opaque block wins.
        for (int i = NUM_BLOCKS - 1; i >= 0; i--) begin
            if (opaque[i]) begin
                pick = pixel_bus[8*i +: 8];
            end
        end

        in_field  = (HW'(dh) >= FX0) && (HW'(dh) < FX1) &&
                    (VW'(dv) >= FY0) && (VW'(dv) < FY1);
        in_border = (HW'(dh) >= BX0) && (HW'(dh) < BX1) &&
                    (VW'(dv) >= BY0) && (VW'(dv) < BY1);

        if (dbl) begin
            rgb_d = 8'h00;
        end else if (seen) begin
            rgb_d = pick;
        end else if (in_field) begin
            rgb_d = BG_COLOR;
        end else if (in_border) begin
            rgb_d = BORDER_COLOR;
        end

        overlap  = !dbl && multi;
        boundary = (dh == 11'd0) && (dv == 10'd0);

        // The boundary pixel opens the new frame's accumulation.
        if (boundary) begin
            fs_d  = 1'b1;
            col_d = (acc_q != 16'd0);
            cnt_d = acc_q;
            acc_d = 16'(overlap);
        end else if (overlap && (acc_q != 16'hFFFF)) begin
            acc_d = acc_q + 16'd1;
        end
    end

    // Output stage and statistics registers.
    always_ff @(posedge vclk or posedge rst) begin
        if (rst) begin
            rgb_q   <= 8'h00;
            hsync_q <= SYNC_IDLE;
            vsync_q <= SYNC_IDLE;
            blank_q <= 1'b1;
            fs_q    <= 1'b0;
            col_q   <= 1'b0;
            cnt_q   <= 16'd0;
            acc_q   <= 16'd0;
        end else begin
            rgb_q   <= rgb_d;
            hsync_q <= dhs_q[PIPE_DELAY-1];
            vsync_q <= dvs_q[PIPE_DELAY-1];
            blank_q <= dbl;
            fs_q    <= fs_d;
            col_q   <= col_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
        end
    end

    assign rgb           = rgb_q;
    assign hsync         = hsync_q;
    assign vsync         = vsync_q;
    assign blank         = blank_q;
    assign frame_start   = fs_q;
    assign collision     = col_q;
    assign overlap_count = cnt_q;

endmodule

// File: tb/tb_block_pixel_compositor.sv
// Bench for block_pixel_compositor: constant-expectation vector table plus a
// cycle scoreboard fed by a reference model of the compositing rules.
module tb_block_pixel_compositor;

    localparam int unsigned NB = 4;
    localparam int unsigned PD = 2;
    localparam logic [31:0] OVP = 32'h0000_2211;

    logic        vclk = 1'b0;
    logic        rst  = 1'b1;
    logic [10:0] hcount = '0;
    logic [9:0]  vcount = '0;
    logic        hsync_in = 1'b1, vsync_in = 1'b1, blank_in = 1'b1;
    logic [8*NB-1:0] pixel_bus = '0;
    logic [NB-1:0]   block_en = '0;
    logic [7:0]  rgb;
    logic        hsync, vsync, blank, frame_start, collision;
    logic [15:0] overlap_count;

    always #5 vclk = ~vclk;

    block_pixel_compositor #(.NUM_BLOCKS(NB), .PIPE_DELAY(PD)) dut (
        .vclk(vclk), .rst(rst), .hcount(hcount), .vcount(vcount),
        .hsync_in(hsync_in), .vsync_in(vsync_in), .blank_in(blank_in),
        .pixel_bus(pixel_bus), .block_en(block_en), .rgb(rgb),
        .hsync(hsync), .vsync(vsync), .blank(blank), .frame_start(frame_start),
        .collision(collision), .overlap_count(overlap_count)
    );

    typedef struct packed {
        logic [7:0]  rgb;
        logic        hs, vs, bl, fs, col;
        logic [15:0] cnt;
    } out_t;

    typedef struct {
        logic [10:0] h;
        logic [9:0]  v;
        logic        bl;
        logic [31:0] pix;
        logic [3:0]  en;
        logic [7:0]  rgb;
    } vec_t;

    out_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    bit   chk_en = 1'b1;

    // Reference model state: timing history and frame statistics.
    logic [10:0] mh  [PD];
    logic [9:0]  mv  [PD];
    logic        mhs [PD], mvs [PD], mbl [PD];
    logic [15:0] macc, mcnt;
    logic        mcol;

    function automatic out_t dut_out();
        return {rgb, hsync, vsync, blank, frame_start, collision, overlap_count};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < PD; i++) begin
            mh[i] = '0; mv[i] = '0; mhs[i] = 1'b1; mvs[i] = 1'b1; mbl[i] = 1'b1;
        end
        macc = '0; mcnt = '0; mcol = 1'b0;
        exp_q.delete();
    endtask

    task automatic drive(input logic [10:0] h, input logic [9:0] v, input logic hs,
                         input logic vs, input logic bl, input logic [31:0] pix,
                         input logic [3:0] en);
        out_t e;
        int ah, av, nop;
        logic abl, any;
        logic [7:0] pick;
        hcount = h; vcount = v; hsync_in = hs; vsync_in = vs; blank_in = bl;
        pixel_bus = pix; block_en = en;
        ah = int'(mh[PD-1]); av = int'(mv[PD-1]); abl = mbl[PD-1];
        e.hs = mhs[PD-1]; e.vs = mvs[PD-1]; e.bl = abl;
        for (int i = PD - 1; i > 0; i--) begin
            mh[i] = mh[i-1]; mv[i] = mv[i-1]; mhs[i] = mhs[i-1];
            mvs[i] = mvs[i-1]; mbl[i] = mbl[i-1];
        end
        mh[0] = h; mv[0] = v; mhs[0] = hs; mvs[0] = vs; mbl[0] = bl;
        nop = 0; any = 1'b0; pick = 8'h00;
        for (int i = 0; i < NB; i++) begin
            logic [7:0] c;
            c = pix[8*i +: 8];
            if (en[i] && c != 8'h00) begin
                nop++;
                if (!any) pick = c;
                any = 1'b1;
            end
        end
        if (abl)                                                   e.rgb = 8'h00;
        else if (any)                                              e.rgb = pick;
        else if (ah >= 200 && ah < 600 && av >= 40 && av < 440)    e.rgb = 8'h24;
        else if (ah >= 196 && ah < 604 && av >= 36 && av < 444)    e.rgb = 8'hFF;
        else                                                       e.rgb = 8'h00;
        if (ah == 0 && av == 0) begin
            e.fs = 1'b1; mcol = (macc != 0); mcnt = macc;
            macc = (!abl && nop >= 2) ? 16'd1 : 16'd0;
        end else begin
            e.fs = 1'b0;
            if (!abl && nop >= 2 && macc != 16'hFFFF) macc = macc + 16'd1;
        end
        e.col = mcol; e.cnt = mcnt;
        exp_q.push_back(e);
        @(posedge vclk);
        #1;
        e = exp_q.pop_front();
        if (chk_en) check("pipe", 32'(dut_out()), 32'(e));
    endtask

    task automatic hold_vec(input vec_t t, input string name);
        repeat (PD + 1) drive(t.h, t.v, 1'b1, 1'b1, t.bl, t.pix, t.en);
        check(name, 32'(rgb), 32'(t.rgb));
    endtask

    // Aligned frame boundary; the last filler carries the boundary pixel.
    task automatic boundary(input bit ov);
        drive(11'd0, 10'd0, 1'b1, 1'b1, 1'b0, 32'h0, 4'h0);
        for (int k = 1; k <= PD; k++)
            drive(11'd1, 10'd0, 1'b1, 1'b1, 1'b0, (ov && k == PD) ? OVP : 32'h0,
                  (ov && k == PD) ? 4'h3 : 4'h0);
    endtask

    task automatic check_reset_outputs(input string name);
        check(name, 32'(dut_out()), 32'({8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0}));
    endtask

    vec_t tbl[13];

    initial begin
        tbl[0]  = '{11'd200, 10'd40,  1'b0, 32'h0, 4'h0, 8'h24};
        tbl[1]  = '{11'd599, 10'd439, 1'b0, 32'h0, 4'h0, 8'h24};
        tbl[2]  = '{11'd196, 10'd40,  1'b0, 32'h0, 4'h0, 8'hFF};
        tbl[3]  = '{11'd600, 10'd100, 1'b0, 32'h0, 4'h0, 8'hFF};
        tbl[4]  = '{11'd195, 10'd40,  1'b0, 32'h0, 4'h0, 8'h00};
        tbl[5]  = '{11'd100, 10'd300, 1'b0, 32'h0, 4'h0, 8'h00};
        tbl[6]  = '{11'd603, 10'd443, 1'b0, 32'h0, 4'h0, 8'hFF};
        tbl[7]  = '{11'd604, 10'd300, 1'b0, 32'h0, 4'h0, 8'h00};
        tbl[8]  = '{11'd300, 10'd35,  1'b0, 32'h0, 4'h0, 8'h00};
        tbl[9]  = '{11'd300, 10'd36,  1'b0, 32'h0, 4'h0, 8'hFF};
        tbl[10] = '{11'd300, 10'd100, 1'b1, 32'h0000_00FF, 4'h1, 8'h00};
        tbl[11] = '{11'd250, 10'd100, 1'b0, 32'h0000_0011, 4'h0, 8'h24};
        tbl[12] = '{11'd300, 10'd100, 1'b0, 32'h00FF_3500, 4'hF, 8'h35};

        // Reset held with random inputs.
        for (int i = 0; i < 5; i++) begin
            hcount = 11'($urandom); vcount = 10'($urandom);
            hsync_in = 1'($urandom); vsync_in = 1'($urandom); blank_in = 1'($urandom);
            pixel_bus = $urandom; block_en = 4'($urandom);
            @(posedge vclk); #1;
            check_reset_outputs("reset_hold");
        end
        rst = 1'b0;
        model_reset();

        for (int i = 0; i < 13; i++) hold_vec(tbl[i], $sformatf("vec%0d", i));

        // Disabling block 1 exposes block 2 on the very next output.
        drive(11'd300, 10'd100, 1'b1, 1'b1, 1'b0, 32'h00FF_3500, 4'hD);
        check("en_off", 32'(rgb), 32'h0000_00FF);

        // Sync pulse appears exactly PD+1 edges later.
        for (int k = 0; k < 4; k++) begin
            drive(11'd300, 10'd100, (k == 0) ? 1'b0 : 1'b1, (k == 0) ? 1'b0 : 1'b1,
                  1'b0, 32'h0, 4'h0);
            check($sformatf("hsync_d%0d", k), 32'(hsync), (k == 2) ? 32'd0 : 32'd1);
            check($sformatf("vsync_d%0d", k), 32'(vsync), (k == 2) ? 32'd0 : 32'd1);
        end

        // Collision report across two boundaries.
        boundary(1'b0);
        repeat (10) drive(11'd300, 10'd100, 1'b1, 1'b1, 1'b0, OVP, 4'h3);
        repeat (5)  drive(11'd300, 10'd100, 1'b1, 1'b1, 1'b0, 32'h0, 4'h0);
        boundary(1'b0);
        check("fs_n",  32'(frame_start), 32'd1);
        check("col_n", 32'(collision), 32'd1);
        check("cnt_n", 32'(overlap_count), 32'd10);
        drive(11'd300, 10'd100, 1'b1, 1'b1, 1'b0, 32'h0, 4'h0);
        check("fs_pulse_end", 32'(frame_start), 32'd0);
        repeat (5) drive(11'd300, 10'd100, 1'b1, 1'b1, 1'b0, 32'h0, 4'h0);
        boundary(1'b0);
        check("col_n1", 32'(collision), 32'd0);
        check("cnt_n1", 32'(overlap_count), 32'd0);

        // Saturation, then a frame whose only overlap is its boundary pixel.
        chk_en = 1'b0;
        repeat (70000) drive(11'd300, 10'd100, 1'b1, 1'b1, 1'b0, OVP, 4'h3);
        chk_en = 1'b1;
        boundary(1'b1);
        check("cnt_sat", 32'(overlap_count), 32'h0000_FFFF);
        check("col_sat", 32'(collision), 32'd1);
        repeat (3) drive(11'd300, 10'd100, 1'b1, 1'b1, 1'b0, 32'h0, 4'h0);
        boundary(1'b0);
        check("cnt_bnd", 32'(overlap_count), 32'd1);

        // Mid-frame async reset discards the partial accumulation.
        repeat (5) drive(11'd300, 10'd100, 1'b1, 1'b1, 1'b0, OVP, 4'h3);
        #3 rst = 1'b1;
        #1 check_reset_outputs("reset_async");
        @(posedge vclk); #1;
        rst = 1'b0;
        model_reset();
        repeat (5) drive(11'd300, 10'd100, 1'b1, 1'b1, 1'b0, 32'h0, 4'h0);
        boundary(1'b0);
        check("fs_post_rst",  32'(frame_start), 32'd1);
        check("col_post_rst", 32'(collision), 32'd0);
        check("cnt_post_rst", 32'(overlap_count), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
